inst_queue: RTL and testbench
=============================

INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter WIDTH, default 2, lanes per push/pop side; legal range 1..8.
REQ-002 Parameter DEPTH, default 8, queue entries; power of two, DEPTH >= 2*WIDTH.
REQ-003 Parameter ENTRY_W, default 64, bits per entry ({pc[31:0], instr[31:0]}).
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous discard of all contents.
REQ-007 push_valid  input  WIDTH  thermometer mask of offered entries, lane 0 oldest.
REQ-008 push_data  input  WIDTH*ENTRY_W  offered entries, lane i at bits [i*ENTRY_W +: ENTRY_W].
REQ-009 push_ready  output  1  free entries >= WIDTH.
REQ-010 pop_valid  output  WIDTH  lane i valid iff occupancy > i.
REQ-011 pop_data  output  WIDTH*ENTRY_W  oldest entries, lane 0 = head.
REQ-012 pop_ready  input  WIDTH  thermometer mask of lanes consumed this cycle.
REQ-013 count  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-014 Storage SHALL be a circular array addressed by head and tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-015 npush SHALL equal the number of contiguous ones from bit 0 of push_valid; bits above the first zero are ignored.
REQ-016 npush SHALL be forced to 0 when push_ready is 0; the push is dropped, not held.
REQ-017 npop SHALL equal min(leading ones of pop_ready, ones of pop_valid).
REQ-018 Each accepted push SHALL write lane i to tail+i (mod DEPTH); tail' = tail+npush.
REQ-019 head' SHALL equal head+npop, and count' SHALL equal count+npush-npop, in the same cycle.
REQ-020 Simultaneous push and pop SHALL be legal at any occupancy, including full and empty.
REQ-021 pop_data lanes with pop_valid low SHALL be driven to zero.
REQ-022 push_ready SHALL be registered-equivalent: a function of count only, never of pop_ready.
REQ-023 Without bypass, an entry pushed in cycle N SHALL first appear on pop_valid in cycle N+1.
REQ-024 flush SHALL take priority over push and pop: next cycle head=tail=0 and count=0, and entries offered during the flush cycle are discarded.
REQ-025 count SHALL never exceed DEPTH and never underflow, for any input combination.

Reset
REQ-026 While reset is low: head=0, tail=0, count=0, pop_valid=0, pop_data=0, push_ready=1.
REQ-027 Reset assertion mid-operation SHALL discard all entries immediately; storage contents are not reset.
REQ-028 The first push SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-029 Macro INST_QUEUE_BYPASS_EN: when defined and count==0 and flush==0, pop_valid/pop_data SHALL mirror the accepted push lanes combinationally in the same cycle.
REQ-030 With INST_QUEUE_BYPASS_EN defined, bypassed lanes consumed by pop_ready SHALL NOT be written; unconsumed lanes SHALL be written starting at tail.
REQ-031 Without INST_QUEUE_BYPASS_EN, REQ-023 latency applies unconditionally, and no combinational path exists from push_* to pop_*.

Structure
REQ-032 The entry typedef (inst_queue_entry_type: pc, instr) SHALL reside in package wires; the default WIDTH and DEPTH constants SHALL reside in package configure.
REQ-033 One sub-module, lead_ones (WIDTH-bit mask in, count of contiguous ones from bit 0 out), SHALL be instantiated for both the push and pop sides.

Verification (WIDTH=2, DEPTH=8, ENTRY_W=64)
REQ-034 Reset, then push_valid=2'b11 with entries A,B -> next cycle count=2, pop_valid=2'b11, pop_data lane0=A, lane1=B.
REQ-035 Fill to count=7 -> push_ready=0; push_valid=2'b11 dropped; pop_ready=2'b01 -> count=6, push_ready=1.
REQ-036 Push 12 entries and pop 2 per cycle with wrap -> output order matches input order across the pointer wrap at 8.
REQ-037 count=3 with push_valid=2'b11 and pop_ready=2'b11 -> count stays 3; push_valid=2'b10 -> npush=0.
REQ-038 count=5 and flush=1 with push_valid=2'b11 -> next cycle count=0, pop_valid=0; reset low mid-stream -> count=0 immediately.
REQ-039 INST_QUEUE_BYPASS_EN with empty queue, push C,D and pop_ready=2'b01 -> same cycle pop_data lane0=C; next cycle count=1 with head=D.

Source files
------------

// File: rtl/inst_queue_pkg.sv
// Shared configuration defaults and inter-stage entry type for inst_queue.
// Optional same-cycle bypass is enabled with macro INST_QUEUE_BYPASS_EN.
package configure;
    localparam int WIDTH_DEF = 2;
    localparam int DEPTH_DEF = 8;
endpackage

package wires;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } inst_queue_entry_type;
endpackage

// File: rtl/inst_queue_if.sv
// Push/pop handshake bundle of inst_queue.
// master drives offers and consumes; slave is the queue itself.
interface inst_queue_if
    import configure::*, wires::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int ENTRY_W = $bits(inst_queue_entry_type)
);
    logic                       flush;
    logic [WIDTH-1:0]           push_valid;
    logic [WIDTH*ENTRY_W-1:0]   push_data;
    logic                       push_ready;
    logic [WIDTH-1:0]           pop_valid;
    logic [WIDTH*ENTRY_W-1:0]   pop_data;
    logic [WIDTH-1:0]           pop_ready;
    logic [$clog2(DEPTH+1)-1:0] count;

    modport master (
        output flush, push_valid, push_data, pop_ready,
        input  push_ready, pop_valid, pop_data, count
    );

    modport slave (
        input  flush, push_valid, push_data, pop_ready,
        output push_ready, pop_valid, pop_data, count
    );
endinterface

// File: rtl/inst_queue_lead_ones.sv
// Counts contiguous ones of a mask starting at bit 0.
// Shared by the push and pop sides of inst_queue.
module lead_ones #(
    parameter int W = 2
) (
    input  logic [W-1:0]           mask,
    output logic [$clog2(W+1)-1:0] n
);
    logic run;

    always_comb begin
        n   = '0;
        run = 1'b1;
        for (int i = 0; i < W; i++) begin
            run = run & mask[i];
            if (run) n = n + 1'b1;
        end
    end
endmodule

// File: rtl/inst_queue.sv
// Multi-lane circular instruction queue with thermometer push/pop lanes.
// Define INST_QUEUE_BYPASS_EN for same-cycle empty-queue bypass.
module inst_queue
    import configure::*, wires::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int ENTRY_W = $bits(inst_queue_entry_type)
) (
    input  logic        clock,
    input  logic        reset,
    inst_queue_if.slave q
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int NW = $clog2(WIDTH + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;
    typedef logic [NW-1:0] num_t;

    logic [ENTRY_W-1:0] mem [DEPTH];

    ptr_t head;
    ptr_t tail;
    cnt_t count_q;

    num_t push_lead;
    num_t pop_lead;
    num_t npush;
    num_t npop;
    num_t nvalid;
    num_t nbyp;
    logic push_ok;

    logic [WIDTH-1:0]         valid_c;
    logic [WIDTH*ENTRY_W-1:0] data_c;
    ptr_t                     wa  [WIDTH];
    logic                     wen [WIDTH];

    lead_ones #(.W(WIDTH)) u_push_lead (
        .mask (q.push_valid),
        .n    (push_lead)
    );

    lead_ones #(.W(WIDTH)) u_pop_lead (
        .mask (q.pop_ready),
        .n    (pop_lead)
    );

    // Depends on stored occupancy only, so no pop_ready -> push_ready path.
    assign push_ok = (DEPTH - int'(count_q)) >= WIDTH;
    assign npush   = push_ok ? push_lead : '0;

`ifdef INST_QUEUE_BYPASS_EN
    logic byp;
    assign byp = (count_q == '0) && !q.flush;
`endif

    always_comb begin
        nvalid = (int'(count_q) >= WIDTH) ? NW'(WIDTH) : NW'(count_q);
        nbyp   = '0;
`ifdef INST_QUEUE_BYPASS_EN
        if (byp) nvalid = npush;
`endif
        npop = (pop_lead < nvalid) ? pop_lead : nvalid;
`ifdef INST_QUEUE_BYPASS_EN
        if (byp) nbyp = npop;
`endif
    end

    always_comb begin
        valid_c = '0;
        data_c  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            valid_c[i] = int'(nvalid) > i;
            if (valid_c[i]) begin
`ifdef INST_QUEUE_BYPASS_EN
                if (byp)
                    data_c[i*ENTRY_W +: ENTRY_W] =
                        q.push_data[i*ENTRY_W +: ENTRY_W];
                else
`endif
                    data_c[i*ENTRY_W +: ENTRY_W] =
                        mem[head + ptr_t'(i)];
            end
        end
    end

    // Lanes already consumed through the bypass never reach storage.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            wa[i]  = tail + ptr_t'(i) - ptr_t'(nbyp);
            wen[i] = !q.flush && (i < int'(npush))
                     && (i >= int'(nbyp));
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < WIDTH; i++) begin
            if (wen[i]) mem[wa[i]] <= q.push_data[i*ENTRY_W +: ENTRY_W];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (q.flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            head    <= head + ptr_t'(npop - nbyp);
            tail    <= tail + ptr_t'(npush - nbyp);
            count_q <= count_q + cnt_t'(npush) - cnt_t'(npop);
        end
    end

    assign q.push_ready = push_ok;
    assign q.pop_valid  = valid_c;
    assign q.pop_data   = data_c;
    assign q.count      = count_q;
endmodule

// File: tb/tb_inst_queue.sv
// Randomized self-checking bench for inst_queue against a queue model.
// Build with INST_QUEUE_BYPASS_EN to also check the bypass path.
module tb_inst_queue;
    import wires::*;

    logic clock;
    logic reset;
    int   checks;
    int   failures;
    int   seq;

    logic [63:0] mq [$];

    inst_queue_if #(.WIDTH(2), .DEPTH(8), .ENTRY_W(64)) bus ();

    inst_queue #(.WIDTH(2), .DEPTH(8), .ENTRY_W(64)) dut (
        .clock (clock),
        .reset (reset),
        .q     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int lead(input logic [1:0] m);
        if (!m[0]) return 0;
        return m[1] ? 2 : 1;
    endfunction

    function automatic logic [63:0] mk();
        inst_queue_entry_type e;
        e.pc    = 32'h1000 + 32'(seq) * 4;
        e.instr = $urandom;
        seq++;
        return e;
    endfunction

    task automatic idle();
        bus.flush      = 1'b0;
        bus.push_valid = '0;
        bus.push_data  = '0;
        bus.pop_ready  = '0;
    endtask

    task automatic peek();
        @(negedge clock);
        #1;
    endtask

    // Drive one cycle, check outputs against the model, then advance it.
    task automatic step(input logic fl, input logic [1:0] pv,
                        input logic [127:0] pd, input logic [1:0] pr);
        logic        rdy;
        logic [1:0]  ev;
        logic [127:0] ed;
        int          np, nvis, npo;
        @(negedge clock);
        bus.flush      = fl;
        bus.push_valid = pv;
        bus.push_data  = pd;
        bus.pop_ready  = pr;
        #1;
        rdy  = (8 - mq.size()) >= 2;
        np   = rdy ? lead(pv) : 0;
        ev   = '0;
        ed   = '0;
        nvis = 0;
        for (int i = 0; i < 2; i++) begin
            if (i < mq.size()) begin
                ev[i] = 1'b1;
                ed[i*64 +: 64] = mq[i];
                nvis++;
            end
        end
`ifdef INST_QUEUE_BYPASS_EN
        if (mq.size() == 0 && !fl) begin
            for (int i = 0; i < np; i++) begin
                ev[i] = 1'b1;
                ed[i*64 +: 64] = pd[i*64 +: 64];
                nvis++;
            end
        end
`endif
        chk("push_ready", 128'(bus.push_ready), 128'(rdy));
        chk("count", 128'(bus.count), 128'(mq.size()));
        chk("pop_valid", 128'(bus.pop_valid), 128'(ev));
        chk("pop_data", bus.pop_data, ed);
        @(posedge clock);
        if (fl) begin
            mq.delete();
        end else begin
            for (int i = 0; i < np; i++) mq.push_back(pd[i*64 +: 64]);
            npo = lead(pr) < nvis ? lead(pr) : nvis;
            repeat (npo) void'(mq.pop_front());
        end
        #1;
        idle();
    endtask

    task automatic push2(input logic [1:0] pv, input logic [1:0] pr);
        logic [127:0] d;
        d[63:0]   = mk();
        d[127:64] = mk();
        step(1'b0, pv, d, pr);
    endtask

    logic [127:0] ab;
    logic [127:0] rd;
    int           guard;

    initial begin
        checks   = 0;
        failures = 0;
        seq      = 0;
        reset    = 1'b0;
        idle();

        repeat (2) @(posedge clock);
        peek();
        chk("rst_count", 128'(bus.count), 128'd0);
        chk("rst_pop_valid", 128'(bus.pop_valid), 128'd0);
        chk("rst_pop_data", bus.pop_data, 128'd0);
        chk("rst_push_ready", 128'(bus.push_ready), 128'd1);
        reset = 1'b1;

        ab[63:0]   = mk();
        ab[127:64] = mk();
        step(1'b0, 2'b11, ab, 2'b00);
        peek();
        chk("ab_count", 128'(bus.count), 128'd2);
        chk("ab_valid", 128'(bus.pop_valid), 128'd3);
        chk("ab_data", bus.pop_data, ab);

        push2(2'b11, 2'b00);
        push2(2'b11, 2'b00);
        push2(2'b01, 2'b00);
        peek();
        chk("full_count", 128'(bus.count), 128'd7);
        chk("full_ready", 128'(bus.push_ready), 128'd0);
        push2(2'b11, 2'b00);
        peek();
        chk("drop_count", 128'(bus.count), 128'd7);
        push2(2'b00, 2'b01);
        peek();
        chk("pop1_count", 128'(bus.count), 128'd6);
        chk("pop1_ready", 128'(bus.push_ready), 128'd1);
        repeat (3) push2(2'b00, 2'b11);

        repeat (6) push2(2'b11, 2'b11);
        guard = 0;
        while (mq.size() != 0 && guard < 8) begin
            push2(2'b00, 2'b11);
            guard++;
        end
        chk("wrap_drained", 128'(mq.size()), 128'd0);

        push2(2'b11, 2'b00);
        push2(2'b01, 2'b00);
        push2(2'b11, 2'b11);
        peek();
        chk("pp3_count", 128'(bus.count), 128'd3);
        push2(2'b10, 2'b00);
        peek();
        chk("pv10_count", 128'(bus.count), 128'd3);

        push2(2'b11, 2'b00);
        peek();
        chk("pre_flush", 128'(bus.count), 128'd5);
        push2(2'b11, 2'b11);
        step(1'b1, 2'b11, '1, 2'b00);
        peek();
        chk("flush_count", 128'(bus.count), 128'd0);
        chk("flush_valid", 128'(bus.pop_valid), 128'd0);

        push2(2'b11, 2'b00);
        push2(2'b11, 2'b00);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("mid_rst_count", 128'(bus.count), 128'd0);
        chk("mid_rst_valid", 128'(bus.pop_valid), 128'd0);
        mq.delete();
        @(negedge clock);
        reset = 1'b1;

`ifdef INST_QUEUE_BYPASS_EN
        ab[63:0]   = mk();
        ab[127:64] = mk();
        @(negedge clock);
        bus.push_valid = 2'b11;
        bus.push_data  = ab;
        bus.pop_ready  = 2'b01;
        #1;
        chk("byp_lane0", 128'(bus.pop_data[63:0]), 128'(ab[63:0]));
        @(posedge clock);
        #1;
        idle();
        mq.push_back(ab[127:64]);
        peek();
        chk("byp_count", 128'(bus.count), 128'd1);
        chk("byp_head", 128'(bus.pop_data[63:0]), 128'(ab[127:64]));
`endif

        for (int n = 0; n < 2000; n++) begin
            rd[63:0]   = mk();
            rd[127:64] = mk();
            step($urandom_range(0, 40) == 0, 2'($urandom),
                 rd, 2'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
